// File: rtl/caliptra_alert_ping_sched.sv
// Round-robin alert ping scheduler: idles for a (optionally jittered) period, pings one enabled
// channel, and flags channels whose ping is not acknowledged in time. Jitter: CALIPTRA_ALERT_PING_JITTER_EN.
module caliptra_alert_ping_sched #(
    parameter int unsigned NumAlerts = 4,
    parameter int unsigned CntW      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic [CntW-1:0]              ping_period_i,
    input  logic [CntW-1:0]              ping_timeout_i,
    input  logic [NumAlerts-1:0]         alert_en_i,
    input  logic [NumAlerts-1:0]         ping_ok_i,
    input  logic [NumAlerts-1:0]         err_clr_i,
    output logic [NumAlerts-1:0]         ping_req_o,
    output logic [NumAlerts-1:0]         ping_timeout_err_o,
    output logic                         busy_o,
    output logic [$clog2(NumAlerts)-1:0] cur_idx_o
);

    localparam int unsigned IdxW = $clog2(NumAlerts);
    localparam int unsigned CndW = IdxW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PING = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       per_cnt_q, per_cnt_d;
    logic [CntW-1:0]       to_cnt_q, to_cnt_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [IdxW-1:0]       cur_idx_q, cur_idx_d;
    logic [NumAlerts-1:0]  req_q, req_d;
    logic [NumAlerts-1:0]  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [NumAlerts-1:0]  err_set;
    logic [CntW-1:0]       reload;

`ifdef CALIPTRA_ALERT_PING_JITTER_EN
    localparam int unsigned SumW = CntW + 1;

    logic [15:0]     lfsr_q, lfsr_d;
    logic [SumW-1:0] reload_sum;

    // Galois LFSR x^16+x^14+x^13+x^11+1, right-shifting form
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign reload_sum = SumW'(ping_period_i) + SumW'(lfsr_q[7:0]);
    assign reload     = reload_sum[CntW] ? {CntW{1'b1}} : reload_sum[CntW-1:0];
`else
    assign reload = ping_period_i;
`endif

    // First enabled channel at or after ptr, wrapping around
    logic            sel_found;
    logic [IdxW-1:0] sel_idx;
    logic [CndW-1:0] cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NumAlerts; i++) begin
            cand = CndW'(ptr_q) + CndW'(i);
            if (cand >= CndW'(NumAlerts)) begin
                cand = cand - CndW'(NumAlerts);
            end
            cand_idx = IdxW'(cand);
            if (!sel_found && alert_en_i[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        to_cnt_d  = to_cnt_q;
        ptr_d     = ptr_q;
        cur_idx_d = cur_idx_q;
        req_d     = '0;
        err_set   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    per_cnt_d = reload;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (per_cnt_q != '0) begin
                    per_cnt_d = per_cnt_q - CntW'(1);
                end else if (sel_found) begin
                    to_cnt_d       = ping_timeout_i;
                    req_d[sel_idx] = 1'b1;
                    cur_idx_d      = sel_idx;
                    ptr_d          = (sel_idx == IdxW'(NumAlerts - 1)) ? '0 : sel_idx + IdxW'(1);
                    state_d        = ST_PING;
                end else begin
                    per_cnt_d = reload;
                end
            end
            ST_PING: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (!alert_en_i[cur_idx_q] || ping_ok_i[cur_idx_q]) begin
                    // Abort or acknowledge; ack beats a simultaneous timeout
                    per_cnt_d = reload;
                    state_d   = ST_WAIT;
                end else if (to_cnt_q == '0) begin
                    err_set[cur_idx_q] = 1'b1;
                    per_cnt_d          = reload;
                    state_d            = ST_WAIT;
                end else begin
                    to_cnt_d = to_cnt_q - CntW'(1);
                    req_d    = req_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_d  = (err_q & ~err_clr_i) | err_set;
        busy_d = (state_d == ST_PING);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            per_cnt_q <= '0;
            to_cnt_q  <= '0;
            ptr_q     <= '0;
            cur_idx_q <= '0;
            req_q     <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ptr_q     <= ptr_d;
            cur_idx_q <= cur_idx_d;
            req_q     <= req_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign ping_req_o         = req_q;
    assign ping_timeout_err_o = err_q;
    assign busy_o             = busy_q;
    assign cur_idx_o          = cur_idx_q;

endmodule

// File: tb/tb_caliptra_alert_ping_sched.sv
// Directed bench for caliptra_alert_ping_sched: a cycle table plus hand sequences for
// round-robin order, timeouts, idle channels and (when built with the jitter macro) period jitter.
module tb_caliptra_alert_ping_sched;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] period;
    logic [W-1:0] timeout;
    logic [N-1:0] alert_en;
    logic [N-1:0] ok;
    logic [N-1:0] clr;
    logic [N-1:0] ping_req;
    logic [N-1:0] err;
    logic         busy;
    logic [1:0]   cur_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    caliptra_alert_ping_sched #(.NumAlerts(N), .CntW(W)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .en_i               (en),
        .ping_period_i      (period),
        .ping_timeout_i     (timeout),
        .alert_en_i         (alert_en),
        .ping_ok_i          (ok),
        .err_clr_i          (clr),
        .ping_req_o         (ping_req),
        .ping_timeout_err_o (err),
        .busy_o             (busy),
        .cur_idx_o          (cur_idx)
    );

    typedef struct {
        logic       en;
        logic [3:0] alert_en;
        logic [3:0] ok;
        logic [3:0] clr;
        logic [3:0] exp_req;
        logic [3:0] exp_err;
        logic       exp_busy;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic e, input logic [3:0] a, input logic [3:0] o,
                                input logic [3:0] c, input logic [3:0] r, input logic [3:0] f,
                                input logic b, input logic [1:0] ix);
        vec_t v;
        v.en = e; v.alert_en = a; v.ok = o; v.clr = c;
        v.exp_req = r; v.exp_err = f; v.exp_busy = b; v.exp_idx = ix;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        en = 1'b0; ok = '0; clr = '0; alert_en = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_req(input logic [3:0] exp, input string nm);
        int n = 0;
        while (ping_req == '0 && n < 20) begin
            step();
            n++;
        end
        chk(nm, 32'(ping_req), 32'(exp));
    endtask

    task automatic count_req(input logic [3:0] lvl, input int exp_len, input string nm);
        int n = 0;
        while (ping_req == lvl && n < 50) begin
            step();
            n++;
        end
        chk(nm, 32'(n), 32'(exp_len));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] seq33[5];
        int         n;

        rst_n = 1'b1; en = 1'b0; period = '0; timeout = '0;
        alert_en = '0; ok = '0; clr = '0;
        do_reset();

        chk("rst_req",  32'(ping_req), 32'h0);
        chk("rst_err",  32'(err),      32'h0);
        chk("rst_busy", 32'(busy),     32'h0);
        chk("rst_idx",  32'(cur_idx),  32'h0);

        // Cycle table: period 0, timeout 2 (Ping lasts 3 cycles without ack)
        vecs[0]  = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vecs[1]  = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1, 0);
        vecs[2]  = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1, 0);
        vecs[3]  = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1, 0);
        vecs[4]  = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0);
        vecs[5]  = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 1, 2);
        vecs[6]  = mk(1, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 0, 2);
        vecs[7]  = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1, 0);
        vecs[8]  = mk(1, 4'b0101, 4'b0010, 4'b0001, 4'b0001, 4'b0000, 1, 0);
        vecs[9]  = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1, 0);
        vecs[10] = mk(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vecs[11] = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1, 2);
        vecs[12] = mk(0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2);
        vecs[13] = mk(0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2);
        vecs[14] = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2);
        vecs[15] = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1, 0);
        vecs[16] = mk(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vecs[17] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vecs[18] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        vecs[19] = mk(1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1, 3);
        vecs[20] = mk(1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1, 3);
        vecs[21] = mk(1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1, 3);
        vecs[22] = mk(1, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 0, 3);
        vecs[23] = mk(1, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 1, 3);

        period = 16'd0; timeout = 16'd2;
        for (int i = 0; i < 24; i++) begin
            en = vecs[i].en; alert_en = vecs[i].alert_en;
            ok = vecs[i].ok; clr = vecs[i].clr;
            step();
            chk($sformatf("v%0d_req", i),  32'(ping_req), 32'(vecs[i].exp_req));
            chk($sformatf("v%0d_err", i),  32'(err),      32'(vecs[i].exp_err));
            chk($sformatf("v%0d_busy", i), 32'(busy),     32'(vecs[i].exp_busy));
            chk($sformatf("v%0d_idx", i),  32'(cur_idx),  32'(vecs[i].exp_idx));
        end
        ok = '0; clr = '0;

        // Round robin, period 3: each Wait spans 4 cycles, ack two cycles after request
        do_reset();
        period = 16'd3; timeout = 16'd10; alert_en = 4'b1111; en = 1'b1;
        seq33[0] = 4'b0001; seq33[1] = 4'b0010; seq33[2] = 4'b0100;
        seq33[3] = 4'b1000; seq33[4] = 4'b0001;
        for (int p = 0; p < 5; p++) begin
            n = 0;
            do begin
                step();
                ok = '0;
                if (ping_req == '0) n++;
            end while (ping_req == '0 && n < 50);
            chk($sformatf("rr%0d_wait", p), 32'(n), 32'd4);
            chk($sformatf("rr%0d_req", p), 32'(ping_req), 32'(seq33[p]));
            step();
            chk($sformatf("rr%0d_hold", p), 32'(ping_req), 32'(seq33[p]));
            ok = ping_req;
        end
        step();
        ok = '0;
        chk("rr_end_req", 32'(ping_req), 32'h0);
        chk("rr_end_err", 32'(err), 32'h0);

        // Unacknowledged pings, period 0, timeout 5
        do_reset();
        period = 16'd0; timeout = 16'd5; alert_en = 4'b0101; en = 1'b1;
        wait_req(4'b0001, "to_req0");
        count_req(4'b0001, 6, "to_len0");
        chk("to_err0", 32'(err), 32'b0001);
        wait_req(4'b0100, "to_req2");
        count_req(4'b0100, 6, "to_len2");
        chk("to_err2", 32'(err), 32'b0101);
        clr = 4'b0001;
        step();
        clr = '0;
        chk("to_clr", 32'(err), 32'b0100);

        // No enabled channels: nothing happens until one appears
        do_reset();
        period = 16'd2; timeout = 16'd4; alert_en = '0; en = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (ping_req != '0 || busy) n++;
        end
        chk("idle_quiet", 32'(n), 32'd0);
        alert_en = 4'b1000;
        n = 0;
        while (ping_req == '0 && n < 3) begin
            step();
            n++;
        end
        chk("idle_late_req", 32'(ping_req), 32'b1000);

`ifdef CALIPTRA_ALERT_PING_JITTER_EN
        begin
            int first_len;
            int diff;
            do_reset();
            period = 16'd100; timeout = 16'd10; alert_en = 4'b1111; en = 1'b1;
            first_len = -1; diff = 0;
            for (int p = 0; p < 8; p++) begin
                n = 0;
                do begin
                    step();
                    ok = '0;
                    if (ping_req == '0) n++;
                end while (ping_req == '0 && n < 400);
                chk($sformatf("jit%0d_range", p), 32'(n >= 101 && n <= 356), 32'd1);
                if (first_len < 0) first_len = n;
                else if (n != first_len) diff = 1;
                ok = ping_req;
            end
            step();
            ok = '0;
            chk("jit_distinct", 32'(diff), 32'd1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/caliptra_alert_ping_sched.md
CALIPTRA_ALERT_PING_SCHED -- requirements
Module: caliptra_alert_ping_sched

Interface
REQ-001 SHALL provide parameter NumAlerts, default 4, meaning number of alert channels pinged (2..32).
REQ-002 SHALL provide parameter CntW, default 16, meaning width of period and timeout counters.
REQ-003 SHALL provide port clk_i  input  1  system clock, all logic rising-edge.
REQ-004 SHALL provide port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port en_i  input  1  scheduler enable (level).
REQ-006 SHALL provide port ping_period_i  input  CntW  idle cycles between pings (quasi-static).
REQ-007 SHALL provide port ping_timeout_i  input  CntW  max cycles to wait for ping completion (quasi-static).
REQ-008 SHALL provide port alert_en_i  input  NumAlerts  per-channel ping enable.
REQ-009 SHALL provide port ping_ok_i  input  NumAlerts  per-channel ping handshake complete pulse from receiver side.
REQ-010 SHALL provide port err_clr_i  input  NumAlerts  per-channel clear pulse for timeout errors.
REQ-011 SHALL provide port ping_req_o  output  NumAlerts  one-hot-or-zero ping request level.
REQ-012 SHALL provide port ping_timeout_err_o  output  NumAlerts  sticky per-channel timeout flag.
REQ-013 SHALL provide port busy_o  output  1  high while in Ping state.
REQ-014 SHALL provide port cur_idx_o  output  $clog2(NumAlerts)  index of channel last selected.

Function
REQ-015 SHALL implement FSM states Idle, Wait, Ping; an illegal encoding SHALL return to Idle next cycle with ping_req_o zero.
REQ-016 Idle: while en_i=0 remain; on en_i=1 load period counter with reload value (REQ-027) and go Wait.
REQ-017 Wait: counter==0 -> select channel; else decrement by 1; Wait therefore lasts reload+1 cycles.
REQ-018 Selection: first index with alert_en_i set, searching from pointer ptr upward with wrap; on success load timeout counter with ping_timeout_i, assert ping_req_o[idx] next cycle, cur_idx_o=idx, ptr=(idx+1) mod NumAlerts, go Ping.
REQ-019 Selection with alert_en_i all zero: no request, reload period, stay Wait, ptr unchanged.
REQ-020 Ping: ping_req_o[idx] held high; ping_ok_i[idx]=1 -> deassert next cycle, reload period, go Wait.
REQ-021 Ping: timeout counter==0 and ping_ok_i[idx]=0 -> set ping_timeout_err_o[idx], deassert request, reload period, go Wait; otherwise decrement.
REQ-022 ok and timeout expiry in same cycle: ok wins, no error.
REQ-023 ping_ok_i bits other than idx SHALL be ignored in all states.
REQ-024 alert_en_i[idx] dropping during Ping: abort, deassert request, no error, reload period, go Wait.
REQ-025 en_i=0 in any state: go Idle next cycle, ping_req_o zero; error flags and ptr retained.
REQ-026 err_clr_i[k] clears flag k next cycle; set and clear of same bit in one cycle: set wins.
REQ-027 Reload value SHALL be ping_period_i unless modified by REQ-031.
REQ-028 busy_o SHALL equal (state==Ping); ping_req_o SHALL never have more than one bit set.

Reset
REQ-029 On rst_ni low: state Idle, ptr=0, cur_idx_o=0, ping_req_o=0, ping_timeout_err_o=0, busy_o=0, counters=0, LFSR at seed; effective asynchronously, release synchronous to clk_i.

Configuration
REQ-030 Macro CALIPTRA_ALERT_PING_JITTER_EN SHALL select period jitter.
REQ-031 Defined: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advances every cycle when en_i=1; reload = ping_period_i + lfsr[7:0], saturating at all-ones of CntW.
REQ-032 Undefined: no LFSR instantiated; reload = ping_period_i exactly.

Verification (macro undefined unless stated)
REQ-033 period=3, timeout=10, alert_en=4'b1111, ok returned 2 cycles after each req -> ping_req_o sequence 0001,0010,0100,1000,0001; each Wait 4 cycles; no errors.
REQ-034 period=0, timeout=5, alert_en=4'b0101, ping_ok_i never -> req[0] high 6 cycles, err=0001, then req[2], err=0101; err_clr_i=0001 -> err=0100.
REQ-035 timeout=4, ping_ok_i[idx] asserted on the cycle timeout counter reaches 0 -> no error, next ping proceeds normally.
REQ-036 en_i dropped during Ping on channel 1 -> ping_req_o=0 next cycle, state Idle; re-enable -> next ping targets channel 2.
REQ-037 alert_en_i=0 for 20 cycles, period=2 -> ping_req_o stays 0, busy_o=0; set alert_en_i=1000 -> req[3] within 3 cycles.
REQ-038 Macro defined, period=100 -> every Wait length in [101,356], at least two distinct lengths across 8 pings.
